// File: rtl/jtframe_bank_arb.sv
// Round-robin arbiter sharing one SDRAM bank read port among up to four ROM slots.
// One bank request is outstanding at a time; returned data is latched per slot.
module jtframe_bank_arb #(
    parameter int AW    = 22,
    parameter int SLOTS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hold,
    input  logic [SLOTS*AW-1:0]   slot_addr,
    input  logic [SLOTS-1:0]      slot_rd,
    output logic [SLOTS-1:0]      slot_ok,
    output logic [SLOTS*16-1:0]   slot_dout,
    output logic [AW-1:0]         ba_addr,
    output logic                  ba_rd,
    input  logic                  ba_ack,
    input  logic                  ba_rdy,
    input  logic [15:0]           sdram_dout,
    output logic                  rfsh_en
);

    localparam int GW = (SLOTS > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [GW-1:0]   ptr, gnt;
    logic [GW-1:0]   pick, cand;
    logic            found, any_elig;
    logic            grant, done, store;
    logic [SLOTS-1:0] valid, elig;
    logic [AW-1:0]   addr_a      [SLOTS];
    logic [AW-1:0]   served_addr [SLOTS];
    logic [15:0]     dout_a      [SLOTS];

    // Unpack the slot buses and form the per-slot data-valid flags.
    always_comb begin
        slot_dout = '0;
        for (int i = 0; i < SLOTS; i++) begin
            addr_a[i]              = slot_addr[i*AW +: AW];
            slot_dout[i*16 +: 16]  = dout_a[i];
        end
    end

    always_comb begin
        slot_ok = '0;
        for (int i = 0; i < SLOTS; i++)
            slot_ok[i] = slot_rd[i] & valid[i] & (addr_a[i] == served_addr[i]);
    end

    assign elig     = slot_rd & ~slot_ok;
    assign any_elig = |elig;

    // First eligible slot scanning upward from ptr, wrapping at SLOTS.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < SLOTS; k++) begin
            cand = GW'((int'(ptr) + k) % SLOTS);
            if (!found && elig[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Bank handshake: ba_rd rises one cycle after a grant and stays high, with
    // ba_addr frozen, until the cycle ba_ack is seen; ba_rdy then marks the single
    // cycle sdram_dout holds the word. A same-cycle ack+rdy completes immediately.
    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!hold && any_elig) begin
                    grant    = 1'b1;
                    state_nx = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ba_ack) begin
                    done     = ba_rdy;
                    state_nx = ba_rdy ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ba_rdy) begin
                    done     = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        rfsh_en = (state == ST_IDLE) & (~any_elig | hold);
    end

    // Data is kept only if the slot still wants the address that was fetched.
    assign store = done & slot_rd[gnt] & (addr_a[gnt] == ba_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ba_rd   <= 1'b0;
            ba_addr <= '0;
            ptr     <= '0;
            gnt     <= '0;
            valid   <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                served_addr[i] <= '0;
                dout_a[i]      <= '0;
            end
        end else begin
            if (grant) begin
                gnt     <= pick;
                ba_addr <= addr_a[pick];
                ba_rd   <= 1'b1;
            end else if (state == ST_REQ && ba_ack) begin
                ba_rd   <= 1'b0;
            end
            if (done)
                ptr <= (gnt == GW'(SLOTS-1)) ? '0 : gnt + 1'b1;
            for (int i = 0; i < SLOTS; i++) begin
                if (!slot_rd[i] || addr_a[i] != served_addr[i])
                    valid[i] <= 1'b0;
                if (store && gnt == GW'(i)) begin
                    valid[i]       <= 1'b1;
                    served_addr[i] <= ba_addr;
                    dout_a[i]      <= sdram_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtframe_bank_arb.sv
// Directed bench for jtframe_bank_arb: a cycle-by-cycle vector table for a
// single-slot fetch, then hand-written multi-cycle sequences for the corner cases.
module tb_jtframe_bank_arb;

    localparam int AW    = 22;
    localparam int SLOTS = 4;

    logic                 clk;
    logic                 rst_n;
    logic                 hold;
    logic [SLOTS*AW-1:0]  slot_addr;
    logic [SLOTS-1:0]     slot_rd;
    logic [SLOTS-1:0]     slot_ok;
    logic [SLOTS*16-1:0]  slot_dout;
    logic [AW-1:0]        ba_addr;
    logic                 ba_rd;
    logic                 ba_ack;
    logic                 ba_rdy;
    logic [15:0]          sdram_dout;
    logic                 rfsh_en;

    int checks = 0;
    int errors = 0;

    jtframe_bank_arb #(.AW(AW), .SLOTS(SLOTS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold       (hold),
        .slot_addr  (slot_addr),
        .slot_rd    (slot_rd),
        .slot_ok    (slot_ok),
        .slot_dout  (slot_dout),
        .ba_addr    (ba_addr),
        .ba_rd      (ba_rd),
        .ba_ack     (ba_ack),
        .ba_rdy     (ba_rdy),
        .sdram_dout (sdram_dout),
        .rfsh_en    (rfsh_en)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rd;
        logic        ack;
        logic        rdy;
        logic [15:0] dout;
        logic        e_rd;
        logic [21:0] e_addr;
        logic [3:0]  e_ok;
        logic        e_rfsh;
        logic [63:0] e_sdout;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; bank pulses last one cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        ba_ack = 1'b0;
        ba_rdy = 1'b0;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        slot_rd = '0;
        hold    = 1'b0;
        ba_ack  = 1'b0;
        ba_rdy  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        slot_addr[i*AW +: AW] = a;
    endtask

    function automatic logic [15:0] dout_of(input int i);
        return slot_dout[i*16 +: 16];
    endfunction

    task automatic wait_rd(output bit found);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ba_rd === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_ba_rd: got timeout expected ba_rd=1");
        end
    endtask

    // Bank model: ack ack_dly cycles after ba_rd is seen, rdy rdy_dly cycles later.
    task automatic serve(input logic [15:0] data, input int ack_dly, input int rdy_dly,
                         output logic [AW-1:0] addr);
        bit f;
        wait_rd(f);
        addr = ba_addr;
        repeat (ack_dly) next_cycle();
        ba_ack = 1'b1;
        if (rdy_dly == 0) begin
            ba_rdy     = 1'b1;
            sdram_dout = data;
        end else begin
            repeat (rdy_dly) next_cycle();
            ba_rdy     = 1'b1;
            sdram_dout = data;
        end
        next_cycle();
    endtask

    initial begin
        logic [AW-1:0] a;
        bit            f;
        bit            seen;

        // vector table: slot1 fetches 0x123; ack 2 cycles after ba_rd, rdy 4 after ack
        vecs[0]  = '{4'h2, 1'b0, 1'b0, 16'h0000, 1'b0, 22'h000, 4'h0, 1'b0, 64'h0};
        vecs[1]  = '{4'h2, 1'b0, 1'b0, 16'h0000, 1'b1, 22'h123, 4'h0, 1'b0, 64'h0};
        vecs[2]  = '{4'h2, 1'b0, 1'b0, 16'h0000, 1'b1, 22'h123, 4'h0, 1'b0, 64'h0};
        vecs[3]  = '{4'h2, 1'b1, 1'b0, 16'h0000, 1'b1, 22'h123, 4'h0, 1'b0, 64'h0};
        vecs[4]  = '{4'h2, 1'b0, 1'b0, 16'h0000, 1'b0, 22'h123, 4'h0, 1'b0, 64'h0};
        vecs[5]  = '{4'h2, 1'b0, 1'b0, 16'h0000, 1'b0, 22'h123, 4'h0, 1'b0, 64'h0};
        vecs[6]  = '{4'h2, 1'b0, 1'b0, 16'h0000, 1'b0, 22'h123, 4'h0, 1'b0, 64'h0};
        vecs[7]  = '{4'h2, 1'b0, 1'b1, 16'hBEEF, 1'b0, 22'h123, 4'h0, 1'b0, 64'h0};
        vecs[8]  = '{4'h2, 1'b0, 1'b0, 16'h0000, 1'b0, 22'h123, 4'h2, 1'b1, 64'h0000_0000_BEEF_0000};
        vecs[9]  = '{4'h2, 1'b0, 1'b0, 16'h0000, 1'b0, 22'h123, 4'h2, 1'b1, 64'h0000_0000_BEEF_0000};
        vecs[10] = '{4'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 22'h123, 4'h0, 1'b1, 64'h0000_0000_BEEF_0000};
        vecs[11] = '{4'h2, 1'b0, 1'b0, 16'h0000, 1'b0, 22'h123, 4'h0, 1'b0, 64'h0000_0000_BEEF_0000};
        vecs[12] = '{4'h0, 1'b1, 1'b1, 16'h1111, 1'b1, 22'h123, 4'h0, 1'b0, 64'h0000_0000_BEEF_0000};
        vecs[13] = '{4'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 22'h123, 4'h0, 1'b1, 64'h0000_0000_BEEF_0000};

        rst_n      = 1'b0;
        hold       = 1'b0;
        slot_addr  = '0;
        slot_rd    = '0;
        ba_ack     = 1'b0;
        ba_rdy     = 1'b0;
        sdram_dout = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ba_rd",   64'(ba_rd),     64'h0);
        chk("reset_ba_addr", 64'(ba_addr),   64'h0);
        chk("reset_slot_ok", 64'(slot_ok),   64'h0);
        chk("reset_dout",    64'(slot_dout), 64'h0);
        chk("reset_rfsh",    64'(rfsh_en),   64'h1);
        next_cycle();
        rst_n = 1'b1;

        // single slot, vector table
        set_addr(1, 22'h00123);
        for (int i = 0; i < 14; i++) begin
            slot_rd    = vecs[i].rd;
            ba_ack     = vecs[i].ack;
            ba_rdy     = vecs[i].rdy;
            sdram_dout = vecs[i].dout;
            @(negedge clk);
            chk($sformatf("vec%0d_ba_rd", i),   64'(ba_rd),     64'(vecs[i].e_rd));
            chk($sformatf("vec%0d_ba_addr", i), 64'(ba_addr),   64'(vecs[i].e_addr));
            chk($sformatf("vec%0d_slot_ok", i), 64'(slot_ok),   64'(vecs[i].e_ok));
            chk($sformatf("vec%0d_rfsh", i),    64'(rfsh_en),   64'(vecs[i].e_rfsh));
            chk($sformatf("vec%0d_dout", i),    64'(slot_dout), vecs[i].e_sdout);
            next_cycle();
        end

        // round robin over all four slots, then pointer wrap
        do_reset();
        for (int i = 0; i < 4; i++) set_addr(i, 22'(32'h10 * (i + 1)));
        slot_rd = 4'hF;
        for (int n = 0; n < 4; n++) begin
            serve(16'hA000 + 16'(n), 1, 2, a);
            chk($sformatf("rr%0d_addr", n), 64'(a), 64'(32'h10 * (n + 1)));
            @(negedge clk);
            chk($sformatf("rr%0d_ok", n),   64'(slot_ok), 64'((1 << (n + 1)) - 1));
            chk($sformatf("rr%0d_dout", n), 64'(dout_of(n)), 64'(16'hA000 + 16'(n)));
            chk($sformatf("rr%0d_gap", n),  64'(ba_rd), 64'h0);
        end
        seen = 1'b0;
        repeat (4) begin
            next_cycle();
            @(negedge clk);
            if (ba_rd) seen = 1'b1;
        end
        chk("rr_no_regrant", 64'(seen), 64'h0);
        chk("rr_rfsh", 64'(rfsh_en), 64'h1);
        next_cycle();
        set_addr(0, 22'h11);
        set_addr(2, 22'h31);
        serve(16'hB000, 1, 1, a);
        chk("wrap_first_addr", 64'(a), 64'h11);
        serve(16'hB002, 1, 1, a);
        chk("wrap_second_addr", 64'(a), 64'h31);
        @(negedge clk);
        chk("wrap_ok", 64'(slot_ok), 64'hF);

        // stale return: slot2 moves its address while the read is in WAIT
        do_reset();
        slot_addr = '0;
        set_addr(2, 22'h55);
        slot_rd = 4'h4;
        wait_rd(f);
        chk("stale_addr", 64'(ba_addr), 64'h55);
        next_cycle();
        ba_ack = 1'b1;
        next_cycle();
        set_addr(2, 22'h56);
        next_cycle();
        ba_rdy     = 1'b1;
        sdram_dout = 16'h7777;
        next_cycle();
        @(negedge clk);
        chk("stale_ok",   64'(slot_ok), 64'h0);
        chk("stale_dout", 64'(dout_of(2)), 64'h0);
        serve(16'h5656, 1, 1, a);
        chk("stale_regrant_addr", 64'(a), 64'h56);
        @(negedge clk);
        chk("stale_regrant_ok",   64'(slot_ok), 64'h4);
        chk("stale_regrant_dout", 64'(dout_of(2)), 64'h5656);

        // hold raised during WAIT
        do_reset();
        slot_addr = '0;
        set_addr(0, 22'h100);
        set_addr(3, 22'h300);
        slot_rd = 4'h9;
        wait_rd(f);
        chk("hold_first_addr", 64'(ba_addr), 64'h100);
        next_cycle();
        ba_ack = 1'b1;
        next_cycle();
        hold = 1'b1;
        next_cycle();
        ba_rdy     = 1'b1;
        sdram_dout = 16'h1234;
        next_cycle();
        @(negedge clk);
        chk("hold_ok",   64'(slot_ok), 64'h1);
        chk("hold_dout", 64'(dout_of(0)), 64'h1234);
        chk("hold_rfsh", 64'(rfsh_en), 64'h1);
        seen = 1'b0;
        repeat (5) begin
            next_cycle();
            @(negedge clk);
            if (ba_rd) seen = 1'b1;
        end
        chk("hold_no_grant", 64'(seen), 64'h0);
        next_cycle();
        hold = 1'b0;
        @(negedge clk);
        chk("unhold_rfsh",  64'(rfsh_en), 64'h0);
        chk("unhold_ba_rd", 64'(ba_rd), 64'h0);
        serve(16'h4321, 1, 1, a);
        chk("unhold_addr", 64'(a), 64'h300);
        @(negedge clk);
        chk("unhold_ok",   64'(slot_ok), 64'h9);
        chk("unhold_dout", 64'(dout_of(3)), 64'h4321);

        // ack and rdy in the same REQ cycle
        do_reset();
        slot_addr = '0;
        set_addr(1, 22'h2A);
        slot_rd = 4'h2;
        wait_rd(f);
        next_cycle();
        ba_ack     = 1'b1;
        ba_rdy     = 1'b1;
        sdram_dout = 16'hCAFE;
        next_cycle();
        @(negedge clk);
        chk("same_ok",    64'(slot_ok), 64'h2);
        chk("same_dout",  64'(dout_of(1)), 64'hCAFE);
        chk("same_ba_rd", 64'(ba_rd), 64'h0);
        chk("same_idle",  64'(rfsh_en), 64'h1);

        // asynchronous reset in the middle of REQ
        do_reset();
        slot_addr = '0;
        set_addr(0, 22'h77);
        set_addr(1, 22'h11);
        slot_rd = 4'h3;
        serve(16'h7700, 1, 1, a);
        chk("arst_first_addr", 64'(a), 64'h77);
        @(negedge clk);
        chk("arst_pre_ok", 64'(slot_ok), 64'h1);
        wait_rd(f);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ba_rd",   64'(ba_rd), 64'h0);
        chk("arst_slot_ok", 64'(slot_ok), 64'h0);
        chk("arst_dout",    64'(slot_dout), 64'h0);
        chk("arst_ba_addr", 64'(ba_addr), 64'h0);
        slot_rd = '0;
        next_cycle();
        rst_n = 1'b1;
        repeat (2) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
